// File: rtl/contact_sched_pkg.sv
// Shared types and constants for the contact-detect scheduler and its
// response buffers.
package contact_sched_pkg;

  localparam int CS_MAX_REQ = 8;
  localparam int CS_IDX_W   = $clog2(CS_MAX_REQ);
  localparam int CS_TID_W   = 16;

  // FP constants shared with the contact-detect block
  localparam logic [31:0] POSITIVEONE = 32'h3F80_0000;
  localparam logic [31:0] KEPSILON    = 32'h3727_C5AC;

  typedef struct packed {
    logic                valid;
    logic [CS_IDX_W-1:0] idx;
    logic [CS_TID_W-1:0] tid;
  } tag_t;

  typedef struct packed {
    logic                hit;
    logic [CS_TID_W-1:0] tid;
  } rsp_entry_t;

endpackage

// File: rtl/contact_sched_rsp_fifo.sv
// Small synchronous FIFO holding contact results for one requester.
// Head data reads as zero whenever the buffer is empty.
module rsp_fifo
  import contact_sched_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_FULL);
  assign head  = valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    do_pop   = pop && valid;
    // a pop frees the slot the push needs, so push-at-full is legal then
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (!(push && full && !pop))
        else $error("rsp_fifo: push into a full buffer");
    end
  end

endmodule

// File: rtl/contact_sched.sv
// Round-robin, credit-gated issue of contact tests onto one fixed-latency
// pipeline, with results steered back into per-requester response buffers.
module contact_sched
  import contact_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PIPE_LAT  = 3,
  parameter int RSP_DEPTH = 2,
  parameter int TID_W     = CS_TID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_u,
  input  logic [NUM_REQ*32-1:0]    req_v,
  input  logic [NUM_REQ*32-1:0]    req_det,
  input  logic [NUM_REQ*TID_W-1:0] req_tid,
  output logic [31:0]              cd_u,
  output logic [31:0]              cd_v,
  output logic [31:0]              cd_det,
  input  logic                     cd_hit,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ-1:0]       rsp_hit,
  output logic [NUM_REQ*TID_W-1:0] rsp_tid,
  output logic                     busy
);

  localparam int CRD_W = $clog2(RSP_DEPTH + 1);
  localparam int IDX_W = CS_IDX_W;
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(RSP_DEPTH);
  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   REQ_N    = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CRD_W-1:0] credit_q [NUM_REQ];
  logic [CRD_W-1:0] credit_d [NUM_REQ];
  // stage 0 travels with the cd_* operand register; the last stage lines up with cd_hit
  tag_t             tag_q [PIPE_LAT+1];
  tag_t             tag_d [PIPE_LAT+1];
  logic [31:0]      cd_u_q, cd_u_d, cd_v_q, cd_v_d, cd_det_q, cd_det_d;

  logic [NUM_REQ-1:0]   eligible, pop, push, rsp_full;
  logic [2*NUM_REQ-1:0] elig_dbl, elig_rot;
  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W:0]       grant_sum;
  logic [TID_W-1:0]     grant_tid;
  logic                 tags_busy;
  tag_t                 tag_out;

  assign cd_u    = cd_u_q;
  assign cd_v    = cd_v_q;
  assign cd_det  = cd_det_q;
  assign tag_out = tag_q[PIPE_LAT];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (credit_q[i] != '0);
    end
  end

  // rotate so bit 0 is the requester at ptr, then take the lowest set bit
  always_comb begin
    elig_dbl  = {eligible, eligible};
    elig_rot  = elig_dbl >> ptr_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        grant_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
        if (grant_sum >= REQ_N) grant_sum = grant_sum - REQ_N;
        grant_vld = 1'b1;
        grant_idx = grant_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_vld && (grant_idx == IDX_W'(i));
    end
    if (grant_vld) ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_ONE;
    else           ptr_d = ptr_q;
  end

  always_comb begin
    cd_u_d    = cd_u_q;
    cd_v_d    = cd_v_q;
    cd_det_d  = cd_det_q;
    grant_tid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        cd_u_d    = req_u[i*32 +: 32];
        cd_v_d    = req_v[i*32 +: 32];
        cd_det_d  = req_det[i*32 +: 32];
        grant_tid = req_tid[i*TID_W +: TID_W];
      end
    end
    tag_d[0].valid = grant_vld;
    tag_d[0].idx   = grant_idx;
    tag_d[0].tid   = grant_tid;
    for (int k = 1; k <= PIPE_LAT; k++) tag_d[k] = tag_q[k-1];
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int k = 0; k <= PIPE_LAT; k++) tags_busy = tags_busy | tag_q[k].valid;
    busy = tags_busy | (|rsp_valid);
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i]  = rsp_valid[i] & rsp_ready[i];
      push[i] = tag_out.valid && (tag_out.idx == IDX_W'(i));
      case ({req_ready[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - CRD_ONE;
        2'b01:   credit_d[i] = credit_q[i] + CRD_ONE;
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      cd_u_q   <= '0;
      cd_v_q   <= '0;
      cd_det_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= CRD_MAX;
      for (int k = 0; k <= PIPE_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cd_u_q   <= cd_u_d;
      cd_v_q   <= cd_v_d;
      cd_det_q <= cd_det_d;
      credit_q <= credit_d;
      tag_q    <= tag_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    rsp_entry_t wr_ent;
    rsp_entry_t rd_ent;
    assign wr_ent.hit = cd_hit;
    assign wr_ent.tid = tag_out.tid;

    rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH ($bits(rsp_entry_t))
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (wr_ent),
      .pop       (pop[i]),
      .valid     (rsp_valid[i]),
      .full      (rsp_full[i]),
      .head      (rd_ent)
    );

    assign rsp_hit[i]                 = rd_ent.hit;
    assign rsp_tid[i*TID_W +: TID_W]  = rd_ent.tid;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!(pop[i] && credit_q[i] == CRD_MAX))
          else $error("contact_sched: credit above depth on requester %0d", i);
        assert (!(push[i] && rsp_full[i] && !pop[i]))
          else $error("contact_sched: response buffer %0d overflow", i);
      end
    end
  end

endmodule

// File: tb/tb_contact_sched.sv
// Bench for contact_sched: vector table, directed corner sequences and a
// random run, all checked against a queue-based reference model.
module tb_contact_sched;

  localparam int NREQ = 4;
  localparam int PLAT = 3;
  localparam int DEP  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_hit;
  logic [127:0]    req_u = '0, req_v = '0, req_det = '0;
  logic [63:0]     req_tid = '0, rsp_tid;
  logic [31:0]     cd_u, cd_v, cd_det;
  logic            cd_hit = 1'b0, busy;

  contact_sched #(.NUM_REQ(NREQ), .PIPE_LAT(PLAT), .RSP_DEPTH(DEP), .TID_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_u(req_u), .req_v(req_v), .req_det(req_det), .req_tid(req_tid),
    .cd_u(cd_u), .cd_v(cd_v), .cd_det(cd_det), .cd_hit(cd_hit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_tid(rsp_tid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [15:0] tid; int due; } fl_t;
  typedef struct { logic [3:0] rv; logic [3:0] rr; logic [3:0] exp; } vec_t;

  fl_t         inflight[$];
  logic [16:0] m_q [NREQ][$];
  int          m_credit [NREQ];
  int          m_ptr, cyc;
  logic [31:0] m_cd_u, m_cd_v, m_cd_det;
  int          n_checks = 0, n_fail = 0;
  logic [3:0]  s_ready, s_rvalid, s_hit;
  logic [63:0] s_tid;
  logic        s_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    inflight.delete();
    for (int i = 0; i < NREQ; i++) begin
      m_q[i].delete();
      m_credit[i] = DEP;
    end
    m_ptr = 0;
    m_cd_u = '0; m_cd_v = '0; m_cd_det = '0;
  endtask

  task automatic do_reset(input bit toggle_hit);
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    m_reset();
    for (int k = 0; k < 3; k++) begin
      cd_hit = toggle_hit ? ~cd_hit : 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_u[i*32 +: 32]   = $urandom;
      req_v[i*32 +: 32]   = $urandom;
      req_det[i*32 +: 32] = $urandom;
      req_tid[i*16 +: 16] = 16'($urandom);
    end
  endtask

  // called at posedge+1; samples at the falling edge, then advances the model
  task automatic step(input logic [3:0] rv, input logic [3:0] rr, input logic hit);
    int   g;
    logic [3:0] exp_ready;
    bit   hv [NREQ];
    req_valid = rv;
    rsp_ready = rr;
    cd_hit    = hit;
    #4;
    s_ready = req_ready; s_rvalid = rsp_valid; s_hit = rsp_hit; s_tid = rsp_tid; s_busy = busy;

    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (g < 0 && rv[j] && m_credit[j] > 0) g = j;
    end
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", {60'd0, req_ready}, {60'd0, exp_ready});
    for (int i = 0; i < NREQ; i++) begin
      hv[i] = (m_q[i].size() > 0);
      chk($sformatf("rsp_valid[%0d]", i), {63'd0, rsp_valid[i]}, {63'd0, hv[i]});
      if (hv[i]) begin
        chk($sformatf("rsp_hit[%0d]", i), {63'd0, rsp_hit[i]}, {63'd0, m_q[i][0][16]});
        chk($sformatf("rsp_tid[%0d]", i), {48'd0, rsp_tid[i*16 +: 16]}, {48'd0, m_q[i][0][15:0]});
      end
    end
    chk("cd_u", {32'd0, cd_u}, {32'd0, m_cd_u});
    chk("cd_v", {32'd0, cd_v}, {32'd0, m_cd_v});
    chk("cd_det", {32'd0, cd_det}, {32'd0, m_cd_det});
    begin
      bit any;
      any = (inflight.size() > 0);
      for (int i = 0; i < NREQ; i++) any = any | hv[i];
      chk("busy", {63'd0, busy}, {63'd0, any});
    end

    for (int i = 0; i < NREQ; i++) begin
      if (hv[i] && rr[i]) begin
        void'(m_q[i].pop_front());
        m_credit[i]++;
      end
    end
    if (g >= 0) begin
      fl_t e;
      m_credit[g]--;
      m_ptr = (g + 1) % NREQ;
      m_cd_u = req_u[g*32 +: 32];
      m_cd_v = req_v[g*32 +: 32];
      m_cd_det = req_det[g*32 +: 32];
      e.idx = g; e.tid = req_tid[g*16 +: 16]; e.due = cyc + 1 + PLAT;
      inflight.push_back(e);
    end
    while (inflight.size() > 0 && inflight[0].due == cyc) begin
      fl_t e;
      e = inflight.pop_front();
      m_q[e.idx].push_back({hit, e.tid});
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  vec_t tbl [11];
  int   cnt;
  int   per [NREQ];

  initial begin
    cyc = 0;
    // state carries from row to row: no pops, so credits only drain
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0001};
    tbl[2]  = '{4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1000, 4'b0000, 4'b1000};
    tbl[4]  = '{4'b0110, 4'b0000, 4'b0010};
    tbl[5]  = '{4'b0111, 4'b0000, 4'b0100};
    tbl[6]  = '{4'b0011, 4'b0000, 4'b0010};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1110, 4'b0000, 4'b0100};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[10] = '{4'b1111, 4'b0000, 4'b0000};

    do_reset(1'b0);
    #1;
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_hit", {60'd0, rsp_hit}, 64'd0);
    chk("rst_rsp_tid", rsp_tid, 64'd0);
    chk("rst_cd", {32'd0, cd_u | cd_v | cd_det}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      rand_ops();
      step(tbl[i].rv, tbl[i].rr, 1'b0);
      chk($sformatf("tbl%0d_ready", i), {60'd0, s_ready}, {60'd0, tbl[i].exp});
    end

    // single request, end-to-end latency
    do_reset(1'b0);
    rand_ops();
    req_tid[15:0] = 16'h0012;
    step(4'b0001, 4'b0000, 1'b0);
    chk("single_grant", {60'd0, s_ready}, 64'd1);
    for (int k = 1; k <= 4; k++) begin
      step(4'b0000, 4'b0000, (k == 4));
      chk($sformatf("single_early_t%0d", k), {60'd0, s_rvalid}, 64'd0);
    end
    step(4'b0000, 4'b0001, 1'b0);
    chk("single_rsp_valid", {63'd0, s_rvalid[0]}, 64'd1);
    chk("single_rsp_hit", {63'd0, s_hit[0]}, 64'd1);
    chk("single_rsp_tid", {48'd0, s_tid[15:0]}, 64'h12);

    // all four requesting and popping: strict rotation, no gaps
    do_reset(1'b0);
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      step(4'b1111, 4'b1111, k[0]);
      chk($sformatf("rr_grant%0d", k), {60'd0, s_ready}, {60'd0, 4'b0001 << (k % 4)});
    end
    for (int k = 0; k < 8; k++) step(4'b0000, 4'b1111, 1'b0);

    // requester 2 never pops: exactly DEP grants, then one per pop
    do_reset(1'b0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step(4'b0100, 4'b0000, 1'b1);
      cnt += int'(s_ready[2]);
    end
    chk("r2_grants_no_pop", 64'(cnt), 64'd2);
    step(4'b0100, 4'b0100, 1'b0);
    chk("r2_no_grant_on_pop_cycle", {60'd0, s_ready}, 64'd0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step(4'b0100, 4'b0000, 1'b0);
      cnt += int'(s_ready[2]);
    end
    chk("r2_grants_after_pop", 64'(cnt), 64'd1);

    // credit=1 with issue and pop in the same cycle keeps credit at 1
    step(4'b0000, 4'b0100, 1'b0);
    rand_ops();
    step(4'b0100, 4'b0100, 1'b1);
    chk("edge_issue_pop", {60'd0, s_ready}, 64'h4);
    step(4'b0100, 4'b0000, 1'b0);
    chk("edge_credit_still_1", {60'd0, s_ready}, 64'h4);
    step(4'b0100, 4'b0000, 1'b0);
    chk("edge_credit_now_0", {60'd0, s_ready}, 64'd0);

    // reset with three tests in flight, pipeline output still toggling
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      step(4'b1111, 4'b0000, k[0]);
    end
    do_reset(1'b1);
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      step(4'b0000, 4'b0000, 1'b1);
      chk($sformatf("idle_hit_no_push%0d", k), {60'd0, s_rvalid}, 64'd0);
    end
    per = '{default: 0};
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step(4'b1111, 4'b0000, 1'b0);
      if (k == 0) chk("midrst_ptr0", {60'd0, s_ready}, 64'd1);
      for (int i = 0; i < NREQ; i++) per[i] += int'(s_ready[i]);
    end
    for (int i = 0; i < NREQ; i++) chk($sformatf("midrst_credit%0d", i), 64'(per[i]), 64'd2);

    // random traffic against the model
    do_reset(1'b0);
    for (int k = 0; k < 600; k++) begin
      rand_ops();
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 12; k++) step(4'b0000, 4'b1111, 1'b1);
    chk("final_busy", {63'd0, s_busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
